// File: rtl/motor_ramp_ctrl.sv
// Motor duty ramp controller: slews duty toward a commanded target on a
// periodic tick, with brake and dead time before any direction reversal.
module motor_ramp_ctrl #(
  parameter int TICK_CYC   = 24000,
  parameter int STEP       = 10,
  parameter int DEAD_TICKS = 50
) (
  input  logic        clk_24M,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [10:0] cmd_duty,
  input  logic        cmd_dir,
  input  logic        estop,
  output logic [10:0] duty,
  output logic        dir,
  output logic        at_target
);

  localparam int TW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int DW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYC - 1);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_TICKS - 1);
  localparam logic [11:0]   STEP_W    = 12'(STEP);
  localparam logic [10:0]   DUTY_MAX  = 11'd1000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAMP,
    S_BRAKE,
    S_DEAD,
    S_ESTOP
  } state_e;

  state_e        state_q, state_d;
  logic [10:0]   duty_q, duty_d;
  logic [10:0]   target_q, target_d;
  logic          dir_q, dir_d;
  logic          pend_dir_q, pend_dir_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [DW-1:0] dead_q, dead_d;

  logic          tick;
  logic          accept;
  logic [10:0]   cmd_clamp;
  logic [11:0]   up_sum;
  logic [10:0]   up_val;
  logic [10:0]   dn_val;
  logic [10:0]   br_val;

  assign tick      = (tick_q == TICK_LAST);
  assign cmd_ready = (state_q == S_IDLE) ||
                     (state_q == S_RAMP) ||
                     (state_q == S_BRAKE);
  assign accept    = cmd_valid && cmd_ready;
  assign cmd_clamp = (cmd_duty > DUTY_MAX) ? DUTY_MAX : cmd_duty;

  // saturating steps: never past target, never below zero
  assign up_sum = {1'b0, duty_q} + STEP_W;
  assign up_val = (up_sum > {1'b0, target_q}) ?
                  target_q : up_sum[10:0];
  assign dn_val = ({1'b0, duty_q} > ({1'b0, target_q} + STEP_W)) ?
                  (duty_q - STEP_W[10:0]) : target_q;
  assign br_val = ({1'b0, duty_q} > STEP_W) ?
                  (duty_q - STEP_W[10:0]) : 11'd0;

  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    target_d   = target_q;
    dir_d      = dir_q;
    pend_dir_d = pend_dir_q;
    dead_d     = dead_q;
    tick_d     = tick ? '0 : tick_q + TW'(1);

    if (estop) begin
      duty_d   = '0;
      target_d = '0;
      state_d  = S_ESTOP;
    end else begin
      case (state_q)
        S_RAMP: begin
          if (tick) begin
            if (duty_q < target_q)      duty_d  = up_val;
            else if (duty_q > target_q) duty_d  = dn_val;
            else                        state_d = S_IDLE;
          end
        end
        S_BRAKE: begin
          if (tick) begin
            if (duty_q == '0) begin
              state_d = S_DEAD;
              dead_d  = '0;
            end else begin
              duty_d = br_val;
            end
          end
        end
        S_DEAD: begin
          if (tick) begin
            dead_d = dead_q + DW'(1);
            if (dead_q == DEAD_LAST) begin
              dir_d   = pend_dir_q;
              state_d = S_RAMP;
            end
          end
        end
        S_ESTOP: begin
          duty_d  = '0;
          state_d = S_IDLE;
        end
        default: ;
      endcase

      // a new command holds duty for this edge; stepping resumes next tick
      if (accept) begin
        target_d   = cmd_clamp;
        pend_dir_d = cmd_dir;
        duty_d     = duty_q;
        if (cmd_dir == dir_q) begin
          state_d = S_RAMP;
        end else if (duty_q != '0) begin
          state_d = S_BRAKE;
        end else begin
          state_d = S_DEAD;
          dead_d  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_24M or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      duty_q     <= '0;
      target_q   <= '0;
      dir_q      <= 1'b1;
      pend_dir_q <= 1'b1;
      tick_q     <= '0;
      dead_q     <= '0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      target_q   <= target_d;
      dir_q      <= dir_d;
      pend_dir_q <= pend_dir_d;
      tick_q     <= tick_d;
      dead_q     <= dead_d;
    end
  end

  assign duty      = duty_q;
  assign dir       = dir_q;
  assign at_target = (state_q == S_IDLE);

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl with a 4-cycle tick, step 10,
// and a 2-tick dead time.
module tb_motor_ramp_ctrl;

  logic        clk_24M = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [10:0] cmd_duty;
  logic        cmd_dir;
  logic        estop;
  logic [10:0] duty;
  logic        dir;
  logic        at_target;

  int errors = 0;
  int checks = 0;
  int ecount = 0;

  motor_ramp_ctrl #(
    .TICK_CYC  (4),
    .STEP      (10),
    .DEAD_TICKS(2)
  ) dut (
    .clk_24M  (clk_24M),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_duty (cmd_duty),
    .cmd_dir  (cmd_dir),
    .estop    (estop),
    .duty     (duty),
    .dir      (dir),
    .at_target(at_target)
  );

  always #5 clk_24M = ~clk_24M;

  task automatic clk_edge;
    @(posedge clk_24M);
    #1;
    ecount++;
  endtask

  // advance to the edge on which the tick counter wraps
  task automatic next_tick;
    int k;
    k = 0;
    do begin
      clk_edge();
      k++;
    end while ((ecount % 4) != 0 && k < 8);
  endtask

  task automatic send(input logic [10:0] d, input logic r);
    cmd_valid = 1'b1;
    cmd_duty  = d;
    cmd_dir   = r;
    clk_edge();
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clk_edge();
    clk_edge();
    rst = 1'b0;
    ecount = 0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clk_edge();
    clk_edge();
    checks++;
    if (duty !== 11'd0) begin
      errors++;
      $display("FAIL reset_duty got=%0d exp=0", duty);
    end
    checks++;
    if (dir !== 1'b1) begin
      errors++;
      $display("FAIL reset_dir got=%b exp=1", dir);
    end
    checks++;
    if (at_target !== 1'b1) begin
      errors++;
      $display("FAIL reset_at_target got=%b exp=1", at_target);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready);
    end
    rst = 1'b0;
    ecount = 0;
  endtask

  task automatic test_ramp_up;
    int exp_d[4] = '{10, 20, 30, 35};
    send(11'd35, 1'b1);
    checks++;
    if (at_target !== 1'b0) begin
      errors++;
      $display("FAIL up_accept at_target got=%b exp=0", at_target);
    end
    foreach (exp_d[i]) begin
      next_tick();
      checks++;
      if (duty !== 11'(exp_d[i])) begin
        errors++;
        $display("FAIL up_step%0d duty got=%0d exp=%0d",
                 i, duty, exp_d[i]);
      end
    end
    next_tick();
    checks++;
    if (at_target !== 1'b1 || duty !== 11'd35) begin
      errors++;
      $display("FAIL up_done at_target=%b duty=%0d exp 1/35",
               at_target, duty);
    end
  endtask

  task automatic test_ramp_down;
    int exp_d[4] = '{25, 15, 5, 0};
    send(11'd0, 1'b1);
    foreach (exp_d[i]) begin
      next_tick();
      checks++;
      if (duty !== 11'(exp_d[i])) begin
        errors++;
        $display("FAIL down_step%0d duty got=%0d exp=%0d",
                 i, duty, exp_d[i]);
      end
    end
    next_tick();
    checks++;
    if (at_target !== 1'b1 || duty !== 11'd0) begin
      errors++;
      $display("FAIL down_done at_target=%b duty=%0d exp 1/0",
               at_target, duty);
    end
  endtask

  task automatic test_back_to_back;
    send(11'd50, 1'b1);
    send(11'd20, 1'b1);
    next_tick();
    next_tick();
    checks++;
    if (duty !== 11'd20) begin
      errors++;
      $display("FAIL override duty got=%0d exp=20", duty);
    end
    next_tick();
    checks++;
    if (at_target !== 1'b1 || duty !== 11'd20) begin
      errors++;
      $display("FAIL override_done at_target=%b duty=%0d exp 1/20",
               at_target, duty);
    end
    send(11'd20, 1'b1);
    checks++;
    if (at_target !== 1'b0) begin
      errors++;
      $display("FAIL same_target accept at_target got=%b exp=0",
               at_target);
    end
    next_tick();
    checks++;
    if (at_target !== 1'b1 || duty !== 11'd20) begin
      errors++;
      $display("FAIL same_target done at_target=%b duty=%0d exp 1/20",
               at_target, duty);
    end
  endtask

  task automatic test_reversal;
    int brk[2] = '{10, 0};
    int rmp[3] = '{10, 20, 30};
    send(11'd30, 1'b0);
    checks++;
    if (cmd_ready !== 1'b1 || at_target !== 1'b0) begin
      errors++;
      $display("FAIL rev_brake ready=%b at_target=%b exp 1/0",
               cmd_ready, at_target);
    end
    foreach (brk[i]) begin
      next_tick();
      checks++;
      if (duty !== 11'(brk[i]) || dir !== 1'b1) begin
        errors++;
        $display("FAIL rev_brake%0d duty=%0d dir=%b exp %0d/1",
                 i, duty, dir, brk[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      next_tick();
      checks++;
      if (cmd_ready !== 1'b0 || dir !== 1'b1 || duty !== 11'd0) begin
        errors++;
        $display("FAIL rev_dead%0d ready=%b dir=%b duty=%0d exp 0/1/0",
                 i, cmd_ready, dir, duty);
      end
    end
    next_tick();
    checks++;
    if (dir !== 1'b0 || duty !== 11'd0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rev_flip dir=%b duty=%0d ready=%b exp 0/0/1",
               dir, duty, cmd_ready);
    end
    foreach (rmp[i]) begin
      next_tick();
      checks++;
      if (duty !== 11'(rmp[i]) || dir !== 1'b0) begin
        errors++;
        $display("FAIL rev_ramp%0d duty=%0d dir=%b exp %0d/0",
                 i, duty, dir, rmp[i]);
      end
    end
    next_tick();
    checks++;
    if (at_target !== 1'b1) begin
      errors++;
      $display("FAIL rev_done at_target got=%b exp=1", at_target);
    end
  endtask

  task automatic test_cancel;
    int rmp[3] = '{20, 30, 40};
    do_reset();
    send(11'd20, 1'b1);
    next_tick();
    next_tick();
    next_tick();
    send(11'd0, 1'b0);
    next_tick();
    checks++;
    if (duty !== 11'd10 || at_target !== 1'b0) begin
      errors++;
      $display("FAIL cancel_brake duty=%0d at_target=%b exp 10/0",
               duty, at_target);
    end
    send(11'd40, 1'b1);
    foreach (rmp[i]) begin
      next_tick();
      checks++;
      if (duty !== 11'(rmp[i]) || dir !== 1'b1 || cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL cancel_ramp%0d duty=%0d dir=%b ready=%b exp %0d/1/1",
                 i, duty, dir, cmd_ready, rmp[i]);
      end
    end
    next_tick();
    checks++;
    if (at_target !== 1'b1 || duty !== 11'd40) begin
      errors++;
      $display("FAIL cancel_done at_target=%b duty=%0d exp 1/40",
               at_target, duty);
    end
  endtask

  task automatic test_estop;
    send(11'd30, 1'b1);
    next_tick();
    checks++;
    if (duty !== 11'd30) begin
      errors++;
      $display("FAIL estop_pre duty got=%0d exp=30", duty);
    end
    estop     = 1'b1;
    cmd_valid = 1'b1;
    cmd_duty  = 11'd100;
    cmd_dir   = 1'b0;
    clk_edge();
    cmd_valid = 1'b0;
    checks++;
    if (duty !== 11'd0 || cmd_ready !== 1'b0 || dir !== 1'b1 ||
        at_target !== 1'b0) begin
      errors++;
      $display("FAIL estop_hit duty=%0d ready=%b dir=%b at=%b exp 0/0/1/0",
               duty, cmd_ready, dir, at_target);
    end
    next_tick();
    checks++;
    if (duty !== 11'd0 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL estop_hold duty=%0d ready=%b exp 0/0",
               duty, cmd_ready);
    end
    estop = 1'b0;
    clk_edge();
    checks++;
    if (at_target !== 1'b1 || duty !== 11'd0 || dir !== 1'b1) begin
      errors++;
      $display("FAIL estop_exit at=%b duty=%0d dir=%b exp 1/0/1",
               at_target, duty, dir);
    end
    next_tick();
    next_tick();
    checks++;
    if (duty !== 11'd0 || at_target !== 1'b1) begin
      errors++;
      $display("FAIL estop_ignored duty=%0d at=%b exp 0/1",
               duty, at_target);
    end
  endtask

  task automatic test_clamp_reset;
    int n;
    n = 0;
    send(11'd2047, 1'b1);
    while (n < 120) begin
      next_tick();
      n++;
      if (at_target === 1'b1) break;
    end
    checks++;
    if (n != 101 || duty !== 11'd1000) begin
      errors++;
      $display("FAIL clamp ticks=%0d duty=%0d exp 101/1000", n, duty);
    end
    send(11'd500, 1'b1);
    next_tick();
    checks++;
    if (duty !== 11'd990) begin
      errors++;
      $display("FAIL clamp_down duty got=%0d exp=990", duty);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (duty !== 11'd0 || dir !== 1'b1 || at_target !== 1'b1 ||
        cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ramp duty=%0d dir=%b at=%b ready=%b exp 0/1/1/1",
               duty, dir, at_target, cmd_ready);
    end
    clk_edge();
    rst = 1'b0;
    ecount = 0;
  endtask

  task automatic test_reset_dead;
    send(11'd0, 1'b0);
    next_tick();
    next_tick();
    checks++;
    if (dir !== 1'b0 || duty !== 11'd0) begin
      errors++;
      $display("FAIL zero_rev dir=%b duty=%0d exp 0/0", dir, duty);
    end
    next_tick();
    send(11'd0, 1'b1);
    next_tick();
    checks++;
    if (cmd_ready !== 1'b0 || dir !== 1'b0) begin
      errors++;
      $display("FAIL dead_pre ready=%b dir=%b exp 0/0", cmd_ready, dir);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (dir !== 1'b1 || cmd_ready !== 1'b1 || at_target !== 1'b1 ||
        duty !== 11'd0) begin
      errors++;
      $display("FAIL rst_dead dir=%b ready=%b at=%b duty=%0d exp 1/1/1/0",
               dir, cmd_ready, at_target, duty);
    end
    clk_edge();
    rst = 1'b0;
    ecount = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_duty  = '0;
    cmd_dir   = 1'b1;
    estop     = 1'b0;
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_back_to_back();
    test_reversal();
    test_cancel();
    test_estop();
    test_clamp_reset();
    test_reset_dead();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
